parking_lot_counter: RTL and testbench

//  Upstream stage of the parking-lot HEX display: watches two gate photo-sensors (a outer, b inner),

---
 rtl/parking_pkg.sv | 56 +++++
 rtl/parking_lot_counter_car_detect.sv | 115 +++++++++++
 rtl/parking_lot_counter.sv | 68 ++++++
 tb/tb_parking_lot_counter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types and BCD helpers for the parking-lot occupancy counter.
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EN1  = 3'd1,
    EN2  = 3'd2,
    EN3  = 3'd3,
    EX1  = 3'd4,
    EX2  = 3'd5,
    EX3  = 3'd6
  } gate_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t DIGIT_MAX = 4'd9;
  localparam bcd_digit_t DIGIT_MIN = 4'd0;

  function automatic logic [7:0] to_bcd8(input int unsigned value);
    bcd_digit_t tens;
    bcd_digit_t ones;
    tens = bcd_digit_t'((value / 32'd10) % 32'd10);
    ones = bcd_digit_t'(value % 32'd10);
    return {tens, ones};
  endfunction

  // 99 and 00 are held rather than wrapped so digits can never leave 0..9.
  function automatic logic [7:0] bcd_inc8(input logic [7:0] value);
    bcd_digit_t tens;
    bcd_digit_t ones;
    tens = value[7:4];
    ones = value[3:0];
    if (value == 8'h99) begin
      return value;
    end else if (ones == DIGIT_MAX) begin
      return {tens + 4'd1, DIGIT_MIN};
    end else begin
      return {tens, ones + 4'd1};
    end
  endfunction

  function automatic logic [7:0] bcd_dec8(input logic [7:0] value);
    bcd_digit_t tens;
    bcd_digit_t ones;
    tens = value[7:4];
    ones = value[3:0];
    if (value == 8'h00) begin
      return value;
    end else if (ones == DIGIT_MIN) begin
      return {tens - 4'd1, DIGIT_MAX};
    end else begin
      return {tens, ones - 4'd1};
    end
  endfunction

endpackage

// File: rtl/parking_lot_counter_car_detect.sv
// Gate sensor synchroniser plus entry/exit sequence FSM; pulses are a decode of
// registered state and synchronised inputs, registered again by the parent.
module car_detect
  import parking_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  output logic enter_pulse,
  output logic exit_pulse
);

  logic        r_a_meta;
  logic        r_a_sync;
  logic        r_b_meta;
  logic        r_b_sync;
  gate_state_t r_state;
  gate_state_t w_next;
  logic [1:0]  w_ab;
  logic        w_enter;
  logic        w_exit;

  assign w_ab = {r_a_sync, r_b_sync};

  // Two-flop synchronisers and the FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a_meta <= 1'b0;
      r_a_sync <= 1'b0;
      r_b_meta <= 1'b0;
      r_b_sync <= 1'b0;
      r_state  <= IDLE;
    end else begin
      r_a_meta <= a;
      r_a_sync <= r_a_meta;
      r_b_meta <= b;
      r_b_sync <= r_b_meta;
      r_state  <= w_next;
    end
  end

  // Next-state and recognition decode; EX* mirrors EN* with a and b swapped.
  always_comb begin
    w_next  = r_state;
    w_enter = 1'b0;
    w_exit  = 1'b0;
    case (r_state)
      IDLE: begin
        case (w_ab)
          2'b10:   w_next = EN1;
          2'b01:   w_next = EX1;
          default: w_next = IDLE;
        endcase
      end
      EN1: begin
        case (w_ab)
          2'b11:   w_next = EN2;
          2'b10:   w_next = EN1;
          default: w_next = IDLE;
        endcase
      end
      EN2: begin
        case (w_ab)
          2'b01:   w_next = EN3;
          2'b10:   w_next = EN1;
          2'b11:   w_next = EN2;
          default: w_next = IDLE;
        endcase
      end
      EN3: begin
        case (w_ab)
          2'b00: begin
            w_next  = IDLE;
            w_enter = 1'b1;
          end
          2'b11:   w_next = EN2;
          2'b01:   w_next = EN3;
          default: w_next = IDLE;
        endcase
      end
      EX1: begin
        case (w_ab)
          2'b11:   w_next = EX2;
          2'b01:   w_next = EX1;
          default: w_next = IDLE;
        endcase
      end
      EX2: begin
        case (w_ab)
          2'b10:   w_next = EX3;
          2'b01:   w_next = EX1;
          2'b11:   w_next = EX2;
          default: w_next = IDLE;
        endcase
      end
      EX3: begin
        case (w_ab)
          2'b00: begin
            w_next = IDLE;
            w_exit = 1'b1;
          end
          2'b11:   w_next = EX2;
          2'b10:   w_next = EX3;
          default: w_next = IDLE;
        endcase
      end
      default: w_next = IDLE;
    endcase
  end

  assign enter_pulse = w_enter;
  assign exit_pulse  = w_exit;

endmodule

// File: rtl/parking_lot_counter.sv
// Parking-lot occupancy counter: detects car entries/exits and keeps a
// saturating 2-digit BCD count for the HEX display.
module parking_lot_counter
  import parking_pkg::*;
#(
  parameter int unsigned MAX_COUNT = 32'd25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a,
  input  logic       b,
  output logic [7:0] bcd,
  output logic       enter_pulse,
  output logic       exit_pulse,
  output logic       full,
  output logic       empty
);

  localparam logic [7:0] MAX_BCD = to_bcd8(MAX_COUNT);

  logic       w_enter;
  logic       w_exit;
  logic [7:0] w_bcd_next;
  logic [7:0] r_bcd;
  logic       r_enter_pulse;
  logic       r_exit_pulse;

  car_detect u_car_detect (
    .clk         (clk),
    .reset       (reset),
    .a           (a),
    .b           (b),
    .enter_pulse (w_enter),
    .exit_pulse  (w_exit)
  );

  // Saturating count update; pulses still fire when the count is pinned.
  always_comb begin
    w_bcd_next = r_bcd;
    if (w_enter && (r_bcd != MAX_BCD)) begin
      w_bcd_next = bcd_inc8(r_bcd);
    end else if (w_exit && (r_bcd != 8'h00)) begin
      w_bcd_next = bcd_dec8(r_bcd);
    end else begin
      w_bcd_next = r_bcd;
    end
  end

  // Count and pulse registers share the recognition edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bcd         <= 8'h00;
      r_enter_pulse <= 1'b0;
      r_exit_pulse  <= 1'b0;
    end else begin
      r_bcd         <= w_bcd_next;
      r_enter_pulse <= w_enter;
      r_exit_pulse  <= w_exit;
    end
  end

  assign bcd         = r_bcd;
  assign enter_pulse = r_enter_pulse;
  assign exit_pulse  = r_exit_pulse;
  assign full        = (r_bcd == MAX_BCD);
  assign empty       = (r_bcd == 8'h00);

endmodule

// File: tb/tb_parking_lot_counter.sv
// Self-checking bench for parking_lot_counter: table-driven gate sequences with
// a pulse scoreboard, plus hand-written latency and async-reset sequences.
module tb_parking_lot_counter;

  localparam int MAXC = 25;
  localparam logic [9:0] ENT = 10'b00_10_11_01_00;
  localparam logic [9:0] EXT = 10'b00_01_11_10_00;
  localparam logic [9:0] REV = 10'b10_11_10_00_00;
  localparam logic [9:0] INV = 10'b10_01_00_00_00;
  localparam logic [1:0] K_NONE = 2'b00;
  localparam logic [1:0] K_ENT  = 2'b10;
  localparam logic [1:0] K_EXT  = 2'b01;

  logic       clk;
  logic       reset;
  logic       a;
  logic       b;
  logic [7:0] bcd;
  logic       enter_pulse;
  logic       exit_pulse;
  logic       full;
  logic       empty;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] bcd;
  } exp_t;

  typedef struct {
    string      name;
    logic       rst_first;
    logic [9:0] steps;
    int         n;
    logic [1:0] kind;
    int         reps;
    logic [7:0] exp_bcd;
    logic       exp_full;
    logic       exp_empty;
  } vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs[9];
  int   model_count;
  int   n_checks;
  int   n_pass;

  parking_lot_counter #(.MAX_COUNT(32'd25)) dut (
    .clk         (clk),
    .reset       (reset),
    .a           (a),
    .b           (b),
    .bcd         (bcd),
    .enter_pulse (enter_pulse),
    .exit_pulse  (exit_pulse),
    .full        (full),
    .empty       (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] model_bcd(input int c);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(c / 10);
    o = 4'(c % 10);
    return {t, o};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive_step(input logic [1:0] ab, input int cyc);
    {a, b} = ab;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    {a, b} = 2'b00;
    @(negedge clk);
    check("rst_bcd", {24'd0, bcd}, 32'h00);
    check("rst_pulses", {30'd0, enter_pulse, exit_pulse}, 32'd0);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    sb_q.delete();
    model_count = 0;
    reset = 1'b0;
  endtask

  task automatic run_pattern(input logic [9:0] steps, input int n, input logic [1:0] kind);
    for (int i = 0; i < n; i++) begin
      if ((i == n - 1) && (kind != K_NONE)) begin
        if (kind == K_ENT && model_count < MAXC) model_count++;
        else if (kind == K_EXT && model_count > 0) model_count--;
        sb_q.push_back('{kind: kind, bcd: model_bcd(model_count)});
      end
      drive_step(steps[9 - 2 * i -: 2], 2);
    end
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 12 && sb_q.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    #1;
    check({name, "_drain"}, sb_q.size(), 32'd0);
  endtask

  // Scoreboard: every pulse must match the oldest expected recognition.
  always @(negedge clk) begin
    if (!reset && (enter_pulse || exit_pulse)) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, enter_pulse, exit_pulse}, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("pulse_kind", {30'd0, enter_pulse, exit_pulse}, {30'd0, mon_e.kind});
        check("pulse_bcd", {24'd0, bcd}, {24'd0, mon_e.bcd});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    model_count = 0;
    reset       = 1'b1;
    a           = 1'b0;
    b           = 1'b0;

    vecs[0] = '{"t1_entry",      1'b1, ENT, 5, K_ENT,  1,  8'h01, 1'b0, 1'b0};
    vecs[1] = '{"t3_reversal",   1'b0, REV, 4, K_NONE, 1,  8'h01, 1'b0, 1'b0};
    vecs[2] = '{"invalid_seq",   1'b0, INV, 3, K_NONE, 1,  8'h01, 1'b0, 1'b0};
    vecs[3] = '{"t2_exit",       1'b0, EXT, 5, K_EXT,  1,  8'h00, 1'b0, 1'b1};
    vecs[4] = '{"t4_nine",       1'b0, ENT, 5, K_ENT,  9,  8'h09, 1'b0, 1'b0};
    vecs[5] = '{"t4_tenth",      1'b0, ENT, 5, K_ENT,  1,  8'h10, 1'b0, 1'b0};
    vecs[6] = '{"t4_exit",       1'b0, EXT, 5, K_EXT,  1,  8'h09, 1'b0, 1'b0};
    vecs[7] = '{"t5_fill",       1'b1, ENT, 5, K_ENT,  26, 8'h25, 1'b1, 1'b0};
    vecs[8] = '{"t5_exit_empty", 1'b1, EXT, 5, K_EXT,  1,  8'h00, 1'b0, 1'b1};

    for (int v = 0; v < 9; v++) begin
      if (vecs[v].rst_first) apply_reset();
      for (int r = 0; r < vecs[v].reps; r++) run_pattern(vecs[v].steps, vecs[v].n, vecs[v].kind);
      drain(vecs[v].name);
      check({vecs[v].name, "_bcd"}, {24'd0, bcd}, {24'd0, vecs[v].exp_bcd});
      check({vecs[v].name, "_full"}, {31'd0, full}, {31'd0, vecs[v].exp_full});
      check({vecs[v].name, "_empty"}, {31'd0, empty}, {31'd0, vecs[v].exp_empty});
    end

    // Latency: raw 00 reaches the pulse and the count on the third rising edge.
    apply_reset();
    drive_step(2'b10, 2);
    drive_step(2'b11, 2);
    drive_step(2'b01, 2);
    model_count = 1;
    sb_q.push_back('{kind: K_ENT, bcd: model_bcd(1)});
    {a, b} = 2'b00;
    @(negedge clk);
    check("lat_edge1", {31'd0, enter_pulse}, 32'd0);
    @(negedge clk);
    check("lat_edge2", {31'd0, enter_pulse}, 32'd0);
    check("lat_edge2_bcd", {24'd0, bcd}, 32'h00);
    @(negedge clk);
    check("lat_edge3", {31'd0, enter_pulse}, 32'd1);
    check("lat_edge3_bcd", {24'd0, bcd}, 32'h01);
    @(negedge clk);
    check("pulse_width", {31'd0, enter_pulse}, 32'd0);
    drain("latency");

    // Async reset while the FSM sits in EN2 with a count of 07.
    apply_reset();
    for (int r = 0; r < 7; r++) run_pattern(ENT, 5, K_ENT);
    drain("t6_setup");
    check("t6_pre_bcd", {24'd0, bcd}, 32'h07);
    drive_step(2'b10, 2);
    drive_step(2'b11, 3);
    #2 reset = 1'b1;
    #1;
    check("t6_async_bcd", {24'd0, bcd}, 32'h00);
    check("t6_async_empty", {31'd0, empty}, 32'd1);
    sb_q.delete();
    model_count = 0;
    {a, b} = 2'b01;
    @(negedge clk);
    reset = 1'b0;
    drive_step(2'b01, 3);
    drive_step(2'b00, 6);
    check("t6_no_pulse_bcd", {24'd0, bcd}, 32'h00);
    check("t6_no_pulse_empty", {31'd0, empty}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
